// File: rtl/prf_wb_bank_arbiter_pkg.sv
// Shared core types for the PRF writeback path: sizes, PR tag / in-bank index types
// and the writeback request struct.
package prf_wb_bank_arbiter_pkg;

    localparam int PR_COUNT           = 128;
    localparam int LOG_PR_COUNT       = $clog2(PR_COUNT);
    localparam int PRF_BANK_COUNT     = 4;
    localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
    localparam int PRF_WR_COUNT       = 7;
    localparam int XLEN               = 32;
    localparam int BANK_IDX_W         = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

    typedef logic [LOG_PR_COUNT-1:0] pr_tag_t;
    typedef logic [BANK_IDX_W-1:0]   bank_idx_t;

    typedef struct packed {
        pr_tag_t         PR;
        logic [XLEN-1:0] data;
    } prf_wb_req_t;

    // Low PR bits pick the bank so consecutive tags spread across banks.
    function automatic logic [LOG_PRF_BANK_COUNT-1:0] pr_bank(input pr_tag_t pr);
        return pr[LOG_PRF_BANK_COUNT-1:0];
    endfunction

endpackage

// File: rtl/prf_bank_rr_arbiter.sv
// Round-robin arbiter for one PRF bank write port: one-hot grant starting at the
// pointer, pointer advances past the winner with an explicit modulo.
module prf_bank_rr_arbiter #(
    parameter int N = 7
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         grant_valid
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;

    always_comb begin
        int idx;
        grant       = '0;
        gidx        = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                gidx        = PW'(idx);
            end
        end
    end

    // Wrap explicitly at N-1 so a non-power-of-2 count never aliases.
    always_ff @(posedge CLK) begin
        if (rst)
            ptr <= '0;
        else if (grant_valid)
            ptr <= (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
    end

endmodule

// File: rtl/prf_wb_bank_arbiter.sv
// Writeback-to-PRF router: per-bank round-robin over all producers, one registered
// write plus matching complete broadcast per bank per cycle. PR 0 writes are dropped.
module prf_wb_bank_arbiter
    import prf_wb_bank_arbiter_pkg::*;
(
    input  logic                                          CLK,
    input  logic                                          rst,
    input  logic [PRF_WR_COUNT-1:0]                       WB_valid_by_wr,
    input  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]     WB_PR_by_wr,
    input  logic [PRF_WR_COUNT-1:0][XLEN-1:0]             WB_data_by_wr,
    output logic [PRF_WR_COUNT-1:0]                       WB_ready_by_wr,
    output logic [PRF_BANK_COUNT-1:0]                     prf_WEN_by_bank,
    output logic [PRF_BANK_COUNT-1:0][BANK_IDX_W-1:0]     prf_waddr_by_bank,
    output logic [PRF_BANK_COUNT-1:0][XLEN-1:0]           prf_wdata_by_bank,
    output logic [PRF_BANK_COUNT-1:0]                     complete_valid_by_bank,
    output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]   complete_PR_by_bank
);

    logic [PRF_WR_COUNT-1:0]                      pr_zero;
    prf_wb_req_t [PRF_WR_COUNT-1:0]               req_by_wr;
    logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0]  req_by_bank;
    logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0]  grant_by_bank;
    logic [PRF_BANK_COUNT-1:0]                    grant_valid_by_bank;
    prf_wb_req_t [PRF_BANK_COUNT-1:0]             sel_by_bank;

    for (genvar w = 0; w < PRF_WR_COUNT; w++) begin : g_wr
        assign pr_zero[w]   = (WB_PR_by_wr[w] == '0);
        assign req_by_wr[w] = '{PR: WB_PR_by_wr[w], data: WB_data_by_wr[w]};
    end

    for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_bank
        prf_wb_req_t sel;

        // PR 0 never competes for a bank; it is acked and dropped below.
        for (genvar w = 0; w < PRF_WR_COUNT; w++) begin : g_req
            assign req_by_bank[b][w] = WB_valid_by_wr[w] & ~pr_zero[w] &
                (pr_bank(WB_PR_by_wr[w]) == LOG_PRF_BANK_COUNT'(b));
        end

        prf_bank_rr_arbiter #(.N(PRF_WR_COUNT)) u_arb (
            .CLK         (CLK),
            .rst         (rst),
            .req         (req_by_bank[b]),
            .grant       (grant_by_bank[b]),
            .grant_valid (grant_valid_by_bank[b])
        );

        always_comb begin
            sel = '0;
            for (int w = 0; w < PRF_WR_COUNT; w++)
                if (grant_by_bank[b][w]) sel = sel | req_by_wr[w];
        end

        assign sel_by_bank[b] = sel;
    end

    always_comb begin
        logic [PRF_WR_COUNT-1:0] grant_any;
        grant_any = '0;
        for (int b = 0; b < PRF_BANK_COUNT; b++)
            grant_any = grant_any | grant_by_bank[b];
        WB_ready_by_wr = rst ? '0 : (grant_any | (WB_valid_by_wr & pr_zero));
    end

    // Address/data/PR only load on a grant; they are don't-care when WEN is low.
    always_ff @(posedge CLK) begin
        if (rst) begin
            prf_WEN_by_bank        <= '0;
            complete_valid_by_bank <= '0;
            prf_waddr_by_bank      <= '0;
            prf_wdata_by_bank      <= '0;
            complete_PR_by_bank    <= '0;
        end else begin
            prf_WEN_by_bank        <= grant_valid_by_bank;
            complete_valid_by_bank <= grant_valid_by_bank;
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                if (grant_valid_by_bank[b]) begin
                    prf_waddr_by_bank[b]   <= sel_by_bank[b].PR[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
                    prf_wdata_by_bank[b]   <= sel_by_bank[b].data;
                    complete_PR_by_bank[b] <= sel_by_bank[b].PR;
                end
            end
        end
    end

endmodule
